ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-002 Parameter TIMEOUT, default 15, max cycles in RD_WAIT before forced completion; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_req  in  1  requester 0 (CPU data port) access request; held until m0_gnt.
REQ-006 m0_we  in  1  requester 0 write (1) / read (0).
REQ-007 m0_addr  in  32  requester 0 byte address.
REQ-008 m0_wdata  in  32  requester 0 write data.
REQ-009 m0_gnt  out  1  request 0 accepted this cycle.
REQ-010 m0_rdata  out  32  read data to requester 0.
REQ-011 m0_rvalid  out  1  m0_rdata valid, one-cycle pulse.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same widths and meaning for requester 1 (DMA/video reader).
REQ-013 ram_addr  out  ADDR_WIDTH  word address = winner addr[ADDR_WIDTH+1:2].
REQ-014 ram_we  out  1  RAM write strobe.
REQ-015 ram_wdata  out  32  RAM write data.
REQ-016 ram_rdata  in  32  RAM read data.
REQ-017 ram_rdata_valid  in  1  RAM read data valid.
REQ-018 rd_timeout  out  1  one-cycle pulse when a read is force-completed.

Function
REQ-019 FSM states IDLE and RD_WAIT; at most one RAM access outstanding.
REQ-020 In IDLE with any req, arbiter grants exactly one requester in that cycle: gnt combinational, ram_addr/ram_we/ram_wdata driven from winner in same cycle.
REQ-021 Arbitration is round-robin: single requester wins; with both requesting, the requester not granted most recently wins; last-grant pointer resets to 1 (m0 wins first tie).
REQ-022 Granted write: ram_we=1 for that cycle only, FSM stays IDLE, next grant possible next cycle.
REQ-023 Granted read: ram_we=0, owner id latched, FSM -> RD_WAIT next cycle.
REQ-024 In RD_WAIT no gnt asserted; ram_we=0.
REQ-025 In RD_WAIT, ram_rdata_valid=1 -> owner's rdata=ram_rdata and rvalid=1 in that same cycle; FSM -> IDLE; new grant possible next cycle.
REQ-026 ram_rdata_valid in IDLE is ignored; no rvalid to either requester.
REQ-027 Wait counter (8-bit) clears on read grant, increments each RD_WAIT cycle; reaching TIMEOUT without ram_rdata_valid -> owner rvalid=1, rdata=32'hDEAD_BEEF, rd_timeout=1, FSM -> IDLE.
REQ-028 ram_rdata_valid in same cycle counter reaches TIMEOUT: real data wins, rd_timeout=0.
REQ-029 Non-owner rvalid is always 0; rdata outputs hold last delivered value otherwise.
REQ-030 Deassertion of a req before gnt is legal; no access issued for it.

Reset
REQ-031 reset=1 at posedge: FSM=IDLE, pointer=1, counter=0, owner=0, m0/m1_rdata=0; all gnt, rvalid, ram_we, rd_timeout=0 while reset asserted.
REQ-032 Reset during RD_WAIT abandons the read; no rvalid issued, late ram_rdata_valid after reset ignored.
REQ-033 First grant possible the cycle after reset deasserts.

Verification
REQ-034 Both req reads out of reset, RAM latency 1 -> m0_gnt cycle 0, m0_rvalid cycle 1, m1_gnt cycle 2, m1_rvalid cycle 3.
REQ-035 m0 write addr 0x0000_0010 data 0x1234_5678 -> ram_addr=4, ram_we=1 one cycle, ram_wdata=0x1234_5678, m0_gnt=1.
REQ-036 Both continuously requesting writes -> grants alternate m0,m1,m0,m1 on consecutive cycles.
REQ-037 m1 read, ram_rdata_valid held 0 -> m1_rvalid with 0xDEAD_BEEF and rd_timeout after TIMEOUT RD_WAIT cycles; no m0_gnt during wait.
REQ-038 reset asserted in RD_WAIT, ram_rdata_valid pulsed next cycle -> no rvalid, FSM IDLE, outputs at reset values.
REQ-039 ram_rdata_valid pulsed in IDLE with no req -> no rvalid, no state change.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Writes complete in the grant cycle; reads hold the RAM until data returns or a timeout fires.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    input  logic                  ram_rdata_valid,
    output logic                  rd_timeout,
    output logic                  dbg_rd_wait
);

    // Handshake: a requester holds req (with we/addr/wdata stable) until it sees gnt
    // in the same cycle; rvalid is a single-cycle pulse carrying rdata, no back-pressure.

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic        win1;
    logic        we_w;
    logic        deliver;
    logic [31:0] dval;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                                m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        rd_timeout = 1'b0;
        ram_addr   = m0_addr[ADDR_WIDTH+1:2];
        ram_we     = 1'b0;
        ram_wdata  = m0_wdata;
        // On a tie the requester that was not granted last wins.
        win1       = m1_req && (!m0_req || !last_q);
        we_w       = 1'b0;
        deliver    = 1'b0;
        dval       = '0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        m0_gnt    = !win1;
                        m1_gnt    = win1;
                        ram_addr  = win1 ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
                        ram_wdata = win1 ? m1_wdata : m0_wdata;
                        we_w      = win1 ? m1_we : m0_we;
                        ram_we    = we_w;
                        last_d    = win1;
                        if (!we_w) begin
                            state_d = RD_WAIT;
                            owner_d = win1;
                            cnt_d   = 8'd0;
                        end
                    end
                end
                RD_WAIT: begin
                    // Real data takes priority over a timeout in the same cycle.
                    if (ram_rdata_valid) begin
                        deliver = 1'b1;
                        dval    = ram_rdata;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        deliver    = 1'b1;
                        dval       = TIMEOUT_DATA;
                        rd_timeout = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (deliver) begin
                        state_d = IDLE;
                        if (owner_q) begin
                            m1_rvalid  = 1'b1;
                            m1_rdata_d = dval;
                        end else begin
                            m0_rvalid  = 1'b1;
                            m0_rdata_d = dval;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        m0_rdata = m0_rdata_d;
        m1_rdata = m1_rdata_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= 8'd0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign dbg_rd_wait = (state_q == RD_WAIT);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: write-grant vector table, read sequences with a
// read-data scoreboard, timeout, reset-during-read and idle-noise corners.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_rdata_valid;
    logic        rd_timeout, dbg_rd_wait;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    ram_arbiter #(.ADDR_WIDTH(10), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid),
        .rd_timeout(rd_timeout), .dbg_rd_wait(dbg_rd_wait)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        ram_rdata = '0; ram_rdata_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1;
        nxt();
        smp();
        chk1("rst_m0_gnt", m0_gnt, 1'b0);
        chk1("rst_m1_gnt", m1_gnt, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        nxt();
        smp();
        chk32("rst_m0_rdata", m0_rdata, 32'd0);
        chk32("rst_m1_rdata", m1_rdata, 32'd0);
        chk1("rst_state", dbg_rd_wait, 1'b0);
        chk1("rst_timeout", rd_timeout, 1'b0);
        nxt();
        reset = 1'b0;
        idle_inputs();
    endtask

    // Read-data scoreboard: each entry is {owner id, data}.
    always @(negedge clk) begin
        if (m0_rvalid || m1_rvalid) begin
            if (m0_rvalid && m1_rvalid) begin
                chk1("dual_rvalid", 1'b1, 1'b0);
            end else if (exp_q.size() == 0) begin
                chk1("unexpected_rvalid", 1'b1, 1'b0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk1("rvalid_owner", m1_rvalid, e[32]);
                chk32("rdata", m1_rvalid ? m1_rdata : m0_rdata, e[31:0]);
            end
        end
    end

    typedef struct {
        logic        m0_req;
        logic        m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        e_m0_gnt;
        logic        e_m1_gnt;
        logic        chk_bus;
        logic [9:0]  e_addr;
        logic        e_we;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] d0, d1, d2;

        vecs[0] = '{1'b1, 1'b1, 32'h10,   32'h1234_5678, 1'b0, 1'b0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b1, 10'h004, 1'b1, 32'h1234_5678};
        vecs[1] = '{1'b1, 1'b1, 32'h20,   32'hAAAA_0001, 1'b1, 1'b1, 32'h44,  32'hBBBB_0001,
                    1'b0, 1'b1, 1'b1, 10'h011, 1'b1, 32'hBBBB_0001};
        vecs[2] = '{1'b1, 1'b1, 32'h20,   32'hAAAA_0002, 1'b1, 1'b1, 32'h48,  32'hBBBB_0002,
                    1'b1, 1'b0, 1'b1, 10'h008, 1'b1, 32'hAAAA_0002};
        vecs[3] = '{1'b1, 1'b1, 32'h24,   32'hAAAA_0003, 1'b1, 1'b1, 32'h4C,  32'hBBBB_0003,
                    1'b0, 1'b1, 1'b1, 10'h013, 1'b1, 32'hBBBB_0003};
        vecs[4] = '{1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 1'b0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, 32'hFFC, 32'hCCCC_0005,
                    1'b0, 1'b1, 1'b1, 10'h3FF, 1'b1, 32'hCCCC_0005};
        vecs[6] = '{1'b1, 1'b1, 32'h100,  32'hAAAA_0006, 1'b1, 1'b1, 32'h200, 32'hBBBB_0006,
                    1'b1, 1'b0, 1'b1, 10'h040, 1'b1, 32'hAAAA_0006};
        vecs[7] = '{1'b1, 1'b1, 32'h1000, 32'hAAAA_0007, 1'b0, 1'b0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b1, 10'h000, 1'b1, 32'hAAAA_0007};
        vecs[8] = '{1'b1, 1'b1, 32'h8,    32'hAAAA_0008, 1'b1, 1'b1, 32'hC,   32'hBBBB_0008,
                    1'b0, 1'b1, 1'b1, 10'h003, 1'b1, 32'hBBBB_0008};

        idle_inputs();
        reset = 1'b1;
        do_reset();

        // Write-grant table: stays in IDLE, round-robin pointer evolves row to row.
        for (int i = 0; i < 9; i++) begin
            m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we;
            m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
            m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we;
            m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
            smp();
            chk1($sformatf("vec%0d_m0_gnt", i), m0_gnt, vecs[i].e_m0_gnt);
            chk1($sformatf("vec%0d_m1_gnt", i), m1_gnt, vecs[i].e_m1_gnt);
            chk1($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].e_we);
            chk1($sformatf("vec%0d_state", i), dbg_rd_wait, 1'b0);
            if (vecs[i].chk_bus) begin
                chk32($sformatf("vec%0d_ram_addr", i), {22'd0, ram_addr}, {22'd0, vecs[i].e_addr});
                chk32($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
            end
            nxt();
        end
        idle_inputs();

        // Both read out of reset with single-cycle RAM latency.
        do_reset();
        d0 = $urandom; d1 = $urandom;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80;
        smp();
        chk1("rd_c0_m0_gnt", m0_gnt, 1'b1);
        chk1("rd_c0_m1_gnt", m1_gnt, 1'b0);
        chk1("rd_c0_ram_we", ram_we, 1'b0);
        chk32("rd_c0_addr", {22'd0, ram_addr}, 32'h10);
        exp_q.push_back({1'b0, d0});
        nxt();
        m0_req = 1'b0; ram_rdata_valid = 1'b1; ram_rdata = d0;
        smp();
        chk1("rd_c1_m0_rvalid", m0_rvalid, 1'b1);
        chk1("rd_c1_m1_gnt", m1_gnt, 1'b0);
        nxt();
        ram_rdata_valid = 1'b0; ram_rdata = 32'h0;
        smp();
        chk1("rd_c2_m1_gnt", m1_gnt, 1'b1);
        chk32("rd_c2_addr", {22'd0, ram_addr}, 32'h20);
        exp_q.push_back({1'b1, d1});
        nxt();
        m1_req = 1'b0; ram_rdata_valid = 1'b1; ram_rdata = d1;
        smp();
        chk1("rd_c3_m1_rvalid", m1_rvalid, 1'b1);
        nxt();
        ram_rdata_valid = 1'b0; ram_rdata = 32'h5555_5555;
        smp();
        chk32("hold_m0_rdata", m0_rdata, d0);
        chk32("hold_m1_rdata", m1_rdata, d1);
        chk1("hold_m0_rvalid", m0_rvalid, 1'b0);

        // m1 read never answered: forced completion after 4 wait cycles, m0 locked out.
        nxt();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h3F0;
        smp();
        chk1("to_m1_gnt", m1_gnt, 1'b1);
        exp_q.push_back({1'b1, 32'hDEAD_BEEF});
        for (int k = 1; k <= 3; k++) begin
            nxt();
            m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h8; m0_wdata = 32'h0BAD_F00D;
            smp();
            chk1($sformatf("to_wait%0d_m0_gnt", k), m0_gnt, 1'b0);
            chk1($sformatf("to_wait%0d_timeout", k), rd_timeout, 1'b0);
            chk1($sformatf("to_wait%0d_ram_we", k), ram_we, 1'b0);
            chk1($sformatf("to_wait%0d_state", k), dbg_rd_wait, 1'b1);
        end
        nxt();
        smp();
        chk1("to_fire_timeout", rd_timeout, 1'b1);
        chk1("to_fire_m1_rvalid", m1_rvalid, 1'b1);
        chk1("to_fire_m0_gnt", m0_gnt, 1'b0);
        nxt();
        smp();
        chk1("to_after_m0_gnt", m0_gnt, 1'b1);
        chk1("to_after_ram_we", ram_we, 1'b1);
        chk1("to_after_timeout", rd_timeout, 1'b0);

        // Data arrives on the very cycle the timeout would fire; m1 withdraws its request.
        nxt();
        d2 = $urandom_range(32'h7FFF_FFFF, 0);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        smp();
        chk1("edge_m0_gnt", m0_gnt, 1'b1);
        exp_q.push_back({1'b0, d2});
        for (int k = 1; k <= 3; k++) begin
            nxt();
            m0_req = 1'b0; m1_req = (k < 3); m1_we = 1'b1;
            smp();
            chk1($sformatf("edge_wait%0d_m1_gnt", k), m1_gnt, 1'b0);
        end
        nxt();
        m1_req = 1'b0; ram_rdata_valid = 1'b1; ram_rdata = d2;
        smp();
        chk1("edge_timeout", rd_timeout, 1'b0);
        chk1("edge_m0_rvalid", m0_rvalid, 1'b1);
        nxt();
        ram_rdata_valid = 1'b0;
        smp();
        chk1("withdrawn_m1_gnt", m1_gnt, 1'b0);
        chk1("withdrawn_m0_gnt", m0_gnt, 1'b0);
        chk1("withdrawn_state", dbg_rd_wait, 1'b0);

        // Reset lands while a read is outstanding; late RAM data must be dropped.
        nxt();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h44;
        smp();
        chk1("rr_m0_gnt", m0_gnt, 1'b1);
        nxt();
        m0_req = 1'b0; reset = 1'b1;
        smp();
        chk1("rr_rst_m0_rvalid", m0_rvalid, 1'b0);
        chk1("rr_rst_timeout", rd_timeout, 1'b0);
        nxt();
        reset = 1'b0; ram_rdata_valid = 1'b1; ram_rdata = 32'hCAFE_F00D;
        smp();
        chk1("rr_late_m0_rvalid", m0_rvalid, 1'b0);
        chk1("rr_late_m1_rvalid", m1_rvalid, 1'b0);
        chk1("rr_late_state", dbg_rd_wait, 1'b0);
        chk32("rr_late_m0_rdata", m0_rdata, 32'd0);
        chk32("rr_late_m1_rdata", m1_rdata, 32'd0);
        nxt();
        ram_rdata_valid = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
        smp();
        chk1("rr_ptr_m0_gnt", m0_gnt, 1'b1);
        chk1("rr_ptr_m1_gnt", m1_gnt, 1'b0);

        // Stray RAM valid while idle and unrequested.
        nxt();
        idle_inputs();
        ram_rdata_valid = 1'b1; ram_rdata = 32'h1357_9BDF;
        smp();
        chk1("idle_noise_m0_rvalid", m0_rvalid, 1'b0);
        chk1("idle_noise_m1_rvalid", m1_rvalid, 1'b0);
        chk1("idle_noise_gnt", m0_gnt | m1_gnt, 1'b0);
        nxt();
        ram_rdata_valid = 1'b0;
        smp();
        chk1("idle_noise_state", dbg_rd_wait, 1'b0);

        nxt();
        chk32("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
